// File: rtl/i3c_timec_ibi_sched.sv
// Timing-control IBI sequencer: event -> IBI request, NACK retry/backoff, payload MDB + TC bytes.
// Ports: app ev_req/mdb, bus ibi_ack/nack/byte_req/abort, TC ctrl/byte in; TIMEC_TC2_EN adds TC2 byte.
module i3c_timec_ibi_sched #(
  parameter int MAX_RETRY = 3,
  parameter int BACKOFF   = 16,
  parameter int SETTLE    = 4
) (
  input  logic       CLK_SLOW,
  input  logic       RSTn,
  input  logic [2:0] timec_ena,
  input  logic       ev_req,
  input  logic [7:0] mdb,
  input  logic       ibi_ack,
  input  logic       ibi_nack,
  input  logic       byte_req,
  input  logic       bus_abort,
  input  logic [7:0] time_info_byte,
  input  logic       time_overflow,
  output logic       ibi_req,
  output logic       event_start,
  output logic       sc1_stop,
  output logic       sc2_stop,
  output logic [2:0] time_info_sel,
  output logic [7:0] byte_out,
  output logic       byte_vld,
  output logic       byte_last,
  output logic       ev_done,
  output logic       err_nack,
  output logic       ovf_flag
);

`ifdef TIMEC_TC2_EN
  localparam logic [2:0] LAST = 3'd3;
`else
  localparam logic [2:0] LAST = 3'd2;
`endif

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_BACKOFF, S_PAYLOAD
  } st_t;

  st_t        st;
  logic [3:0] retry_cnt;
  logic [7:0] bo_cnt;
  logic [7:0] settle;
  logic [7:0] mdb_q;
  logic [2:0] idx;
  logic       pend;
  logic       s1;
  logic       s1_mdb;
  logic       s1_last;

  logic [3:0] retry_nx;
  logic       in_pl;
  logic       take;
  logic       fire_mdb;
  logic       fire_tc;
  logic       nack_end;
  logic       leave;

  // s1 marks the cycle between select update and byte capture;
  // pend holds a TC byte request until the counters have settled.
  always_comb begin
    retry_nx = (retry_cnt == 4'hf) ? retry_cnt : retry_cnt + 4'd1;
    in_pl    = (st == S_PAYLOAD) && !bus_abort;
    take     = in_pl && byte_req && !pend && !s1 && (idx <= LAST);
    fire_mdb = take && (idx == 3'd0);
    fire_tc  = in_pl && (idx != 3'd0) && (idx <= LAST)
            && (settle == 8'd0) && (pend || take);
    nack_end = (st == S_REQ) && ibi_nack
            && (int'(retry_nx) >= MAX_RETRY);
    leave    = (st != S_IDLE)
            && (bus_abort || nack_end || (in_pl && s1 && s1_last));
  end

  always_ff @(posedge CLK_SLOW or negedge RSTn) begin
    if (!RSTn) begin
      st            <= S_IDLE;
      retry_cnt     <= 4'd0;
      bo_cnt        <= 8'd0;
      settle        <= 8'd0;
      mdb_q         <= 8'd0;
      idx           <= 3'd0;
      pend          <= 1'b0;
      s1            <= 1'b0;
      s1_mdb        <= 1'b0;
      s1_last       <= 1'b0;
      ibi_req       <= 1'b0;
      event_start   <= 1'b0;
      sc1_stop      <= 1'b0;
      sc2_stop      <= 1'b0;
      time_info_sel <= 3'd0;
      byte_out      <= 8'd0;
      byte_vld      <= 1'b0;
      byte_last     <= 1'b0;
      ev_done       <= 1'b0;
      err_nack      <= 1'b0;
      ovf_flag      <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      byte_last <= 1'b0;
      ev_done   <= 1'b0;
      err_nack  <= 1'b0;
      if (settle != 8'd0) settle <= settle - 8'd1;
      if ((st != S_IDLE) && time_overflow) ovf_flag <= 1'b1;
      unique case (st)
        S_IDLE: begin
          if (ev_req && |timec_ena) begin
            st          <= S_REQ;
            ibi_req     <= 1'b1;
            event_start <= 1'b1;
            mdb_q       <= mdb;
            retry_cnt   <= 4'd0;
            ovf_flag    <= 1'b0;
            idx         <= 3'd0;
          end
        end
        S_REQ: begin
          if (ibi_nack) begin
            retry_cnt <= retry_nx;
            err_nack  <= nack_end && !bus_abort;
            st        <= S_BACKOFF;
            ibi_req   <= 1'b0;
            bo_cnt    <= 8'(BACKOFF - 1);
          end else if (ibi_ack) begin
            st       <= S_PAYLOAD;
            ibi_req  <= 1'b0;
            sc1_stop <= 1'b1;
            settle   <= 8'(SETTLE);
          end
        end
        S_BACKOFF: begin
          if (bo_cnt == 8'd0) begin
            st      <= S_REQ;
            ibi_req <= 1'b1;
          end else begin
            bo_cnt <= bo_cnt - 8'd1;
          end
        end
        S_PAYLOAD: begin
          if (fire_mdb) begin
            s1      <= 1'b1;
            s1_mdb  <= 1'b1;
            s1_last <= 1'b0;
            idx     <= idx + 3'd1;
            settle  <= 8'(SETTLE);
`ifdef TIMEC_TC2_EN
            sc2_stop <= 1'b1;
`endif
          end else if (fire_tc) begin
            s1            <= 1'b1;
            s1_mdb        <= 1'b0;
            s1_last       <= (idx == LAST);
            idx           <= idx + 3'd1;
            pend          <= 1'b0;
            time_info_sel <= idx + 3'd4;
          end else if (take) begin
            pend <= 1'b1;
          end
          if (s1 && !bus_abort) begin
            s1        <= 1'b0;
            byte_out  <= s1_mdb ? mdb_q : time_info_byte;
            byte_vld  <= 1'b1;
            byte_last <= s1_last;
            ev_done   <= s1_last;
          end
        end
        default: ;
      endcase
      if (leave) begin
        st            <= S_IDLE;
        ibi_req       <= 1'b0;
        event_start   <= 1'b0;
        sc1_stop      <= 1'b0;
        sc2_stop      <= 1'b0;
        time_info_sel <= 3'd0;
        idx           <= 3'd0;
        pend          <= 1'b0;
        s1            <= 1'b0;
        settle        <= 8'd0;
        bo_cnt        <= 8'd0;
      end
    end
  end

endmodule

// File: doc/i3c_timec_ibi_sched.md
# i3c_timec_ibi_sched

Sequencer for the I3C slave's timing-control In-Band Interrupt. Converts an application event into an IBI request and drives the time-control counter block's `event_start`, `sc1_stop`, `sc2_stop` and `time_info_sel`. Serves the IBI payload bytes (MDB, then captured time bytes) to the bus engine on demand, and handles NACK retry with backoff, bus abort and overflow status. Sits between the application event interface, the bus engine and the time-control counters, all in the `CLK_SLOW` domain.

## Interface
- `MAX_RETRY`, 3: NACKed attempts allowed before the event is dropped (1..15).
- `BACKOFF`, 16: idle cycles between a NACK and re-request (1..255).
- `SETTLE`, 4: cycles after a stop rise before the corresponding TC value is served (≥3).
- `CLK_SLOW`  in  1  sole clock; all logic on its rising edge.
- `RSTn`  in  1  reset, asynchronous, active-low.
- `timec_ena`  in  3  timing-control mode; 0 = disabled (`ev_req` ignored).
- `ev_req`  in  1  level; application event pending.
- `mdb`  in  8  mandatory data byte, sampled when REQ is entered.
- `ibi_ack`, `ibi_nack`  in  1  one-cycle pulses from the bus engine: IBI address ACKed / NACKed by master.
- `byte_req`  in  1  one-cycle pulse requesting the next payload byte.
- `bus_abort`  in  1  one-cycle pulse: STOP or error mid-IBI.
- `time_info_byte`  in  8  byte from the time-control counters.
- `time_overflow`  in  1  one-cycle overflow pulse from the counters.
- `ibi_req`  out  1  IBI request to the bus engine.
- `event_start`, `sc1_stop`, `sc2_stop`  out  1  levels to the time-control counters.
- `time_info_sel`  out  3  counter byte select.
- `byte_out`  out  8  payload byte.
- `byte_vld`  out  1  one-cycle pulse; `byte_out` valid.
- `byte_last`  out  1  qualifies `byte_vld`; final payload byte.
- `ev_done`  out  1  pulse; payload fully served.
- `err_nack`  out  1  pulse; retries exhausted.
- `ovf_flag`  out  1  sticky; overflow seen during the current event.

## Operation
- States: IDLE, REQ, BACKOFF, PAYLOAD.
- IDLE → REQ when `ev_req & |timec_ena`:
  - assert `event_start` and `ibi_req`;
  - latch `mdb`;
  - clear `retry_cnt` and `ovf_flag`.
- REQ behaviour:
  - `ibi_ack` → PAYLOAD; drop `ibi_req`; assert `sc1_stop`; load settle counter with `SETTLE`.
  - `ibi_nack` → increment `retry_cnt`. If it reaches `MAX_RETRY`: pulse `err_nack` and go to IDLE. Otherwise go to BACKOFF; `ibi_req` low.
- BACKOFF: count `BACKOFF` cycles, then go to REQ and reassert `ibi_req`. `event_start` stays high, so the timer keeps measuring from the original event.
- PAYLOAD: each `byte_req` serves the next byte in order:
  - byte 0: MDB;
  - byte 1: `time_info_sel`=5 (TC1 low);
  - byte 2: `time_info_sel`=6 (TC1 high);
  - byte 3: `time_info_sel`=7 (TC2).
- The `byte_req` for byte 0 also asserts `sc2_stop` and reloads the settle counter.
- Time bytes are served only when the settle counter = 0. A request arriving earlier is held pending and served when the counter reaches 0.
- After the last byte: pulse `ev_done`, go to IDLE.
- Leaving to IDLE, for any reason, drops `event_start`, `sc1_stop`, `sc2_stop` and `ibi_req`, and sets `time_info_sel`=0.
- `bus_abort` in any non-IDLE state → IDLE. No `ev_done`, no `err_nack`.
- `time_overflow` in any non-IDLE state sets `ovf_flag`. The flag holds until the next IDLE → REQ; the payload continues with saturated values.
- `byte_req` outside PAYLOAD, or after the last byte, is ignored.
- Precedence in one cycle: `bus_abort` > `ibi_nack` > `ibi_ack`.
- `retry_cnt` is 4 bits, saturating.

## Timing
- Reset: all outputs 0; state IDLE; counters 0.
- `ibi_req` and `event_start` rise 1 cycle after `ev_req` is sampled.
- Byte latency:
  - cycle N: `byte_req` accepted; `time_info_sel` updated (registered).
  - cycle N+1: `byte_out` registered from `time_info_byte` (or from the latched MDB).
  - `byte_vld` is high during cycle N+2 (2-cycle latency).
- A `byte_req` arriving while a byte is in flight is dropped. The bus engine must wait for `byte_vld`.
- NACK to re-request: `ibi_req` high again exactly `BACKOFF`+1 cycles after the `ibi_nack` cycle.

## Configuration
- `TIMEC_TC2_EN` defined:
  - 4-byte payload;
  - `sc2_stop` driven as above;
  - `byte_last` on byte 3.
- `TIMEC_TC2_EN` undefined:
  - 3-byte payload;
  - `sc2_stop` tied 0;
  - `byte_last` on byte 2;
  - selector value 7 is never driven.

## Test plan
- `timec_ena`=1, `ev_req`, `ibi_ack` at cycle 10, four `byte_req` spaced 8 cycles, `time_info_byte` model returns sel×0x11 → `byte_out` 0xA5 (mdb), 0x55, 0x66, 0x77; `byte_last` on the 4th; one `ev_done`.
- `byte_req` for byte 1 issued 1 cycle after the `ibi_ack` acceptance → `byte_vld` delayed until settle counter = 0 (≥`SETTLE`+2 cycles).
- Two `ibi_nack`, then `ibi_ack` → `ibi_req` gaps of 17 cycles, `event_start` continuously high, payload served normally.
- `MAX_RETRY`=3, three `ibi_nack` → `err_nack` pulse on the third NACK, all outputs 0 the next cycle.
- `bus_abort` after byte 1 → IDLE, no `ev_done`; a new `ev_req` restarts with a fresh MDB.
- `time_overflow` pulse in BACKOFF → `ovf_flag`=1 through the payload, cleared at the next event; without `TIMEC_TC2_EN`, 3 bytes and `sc2_stop` always 0.
